mc_controller: RTL and testbench

Multi-cycle successor to the single-cycle MIPS decoder. It decodes the same instruction subset into datapath controls and sequences each instruction through a fetch/decode/execute/memory/writeback state machine. Instruction and data memory are reached through req/rdy handshakes with arbitrary wait states. It sits between the instruction register and the shared datapath: PC, register file, ALU, extender and DM.

---
 rtl/mc_controller.sv | 218 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS-subset control FSM (IF/ID/EX/MEM/WB) with req/rdy memory handshakes.
// Define MC_ILLEGAL_TRAP_EN to trap unrecognised instructions instead of retiring them as NOPs.
module mc_controller #(
   parameter int unsigned WB_COMBINE = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic [5:0] func,
   input  logic       imem_rdy,
   input  logic       dmem_rdy,
   output logic [1:0] RegDst,
   output logic [1:0] RegSrc,
   output logic [3:0] ALUCtr,
   output logic [1:0] nPC_sel,
   output logic       ExtOp,
   output logic       ALUSrc,
   output logic       MemByte,
   output logic       MemHByte,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       ir_we,
   output logic       pc_we,
   output logic       retire,
   output logic [2:0] state,
   output logic       illegal
);

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
`ifdef MC_ILLEGAL_TRAP_EN
   localparam logic [2:0] S_TRAP = 3'd5;
`endif

   logic [2:0] cur, nxt;

   logic       is_alu, is_load, is_store, is_branch, is_jal, id_retire;
   logic [1:0] d_regdst, d_regsrc, d_npc;
   logic [3:0] d_aluctr;
   logic       d_extop, d_alusrc, d_membyte, d_memhbyte;

   logic       dec_en, c_imem_req, c_ir_we, c_dmem_req, c_mem_write, c_reg_write, c_done, c_illegal;

   // Instruction class and static datapath controls; unknown encodings leave everything at 0.
   always_comb begin
      is_alu     = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_branch  = 1'b0;
      is_jal     = 1'b0;
      id_retire  = 1'b0;
      d_regdst   = '0;
      d_regsrc   = '0;
      d_aluctr   = '0;
      d_npc      = '0;
      d_extop    = 1'b0;
      d_alusrc   = 1'b0;
      d_membyte  = 1'b0;
      d_memhbyte = 1'b0;
      case (OpCode)
         6'h00: begin
            case (func)
               6'h21: begin is_alu = 1'b1; d_regdst = 2'b01; d_aluctr = 4'd0; end
               6'h23: begin is_alu = 1'b1; d_regdst = 2'b01; d_aluctr = 4'd1; end
               6'h07: begin is_alu = 1'b1; d_regdst = 2'b01; d_aluctr = 4'd4; end
               6'h08: begin id_retire = 1'b1; d_npc = 2'b11; end
               6'h00: id_retire = 1'b1;
               default: ;
            endcase
         end
         6'h0D: begin is_alu = 1'b1; d_aluctr = 4'd2; d_alusrc = 1'b1; end
         6'h0E: begin is_alu = 1'b1; d_aluctr = 4'd6; d_alusrc = 1'b1; end
         6'h0F: begin is_alu = 1'b1; d_aluctr = 4'd3; d_alusrc = 1'b1; end
         6'h23, 6'h20, 6'h21: begin
            is_load    = 1'b1;
            d_regsrc   = 2'b01;
            d_extop    = 1'b1;
            d_alusrc   = 1'b1;
            d_membyte  = (OpCode == 6'h20);
            d_memhbyte = (OpCode == 6'h21);
         end
         6'h2B, 6'h28, 6'h29: begin
            is_store   = 1'b1;
            d_extop    = 1'b1;
            d_alusrc   = 1'b1;
            d_membyte  = (OpCode == 6'h28);
            d_memhbyte = (OpCode == 6'h29);
         end
         6'h04: begin is_branch = 1'b1; d_aluctr = 4'd1; d_npc = 2'b01; d_extop = 1'b1; end
         6'h01: begin is_branch = 1'b1; d_aluctr = 4'd5; d_npc = 2'b01; d_extop = 1'b1; end
         6'h02: begin id_retire = 1'b1; d_npc = 2'b10; end
         6'h03: begin is_jal = 1'b1; d_regdst = 2'b10; d_regsrc = 2'b10; d_npc = 2'b10; end
         default: ;
      endcase
   end

   always_comb begin
      nxt         = cur;
      dec_en      = 1'b0;
      c_imem_req  = 1'b0;
      c_ir_we     = 1'b0;
      c_dmem_req  = 1'b0;
      c_mem_write = 1'b0;
      c_reg_write = 1'b0;
      c_done      = 1'b0;
      c_illegal   = 1'b0;
      case (cur)
         S_IF: begin
            c_imem_req = 1'b1;
            if (imem_rdy) begin
               c_ir_we = 1'b1;
               nxt     = S_ID;
            end
         end
         S_ID: begin
            dec_en = 1'b1;
            if (id_retire) begin
               c_done = 1'b1;
            end else if (is_jal) begin
               nxt = S_WB;
            end else if (is_alu || is_load || is_store || is_branch) begin
               nxt = S_EX;
            end else begin
`ifdef MC_ILLEGAL_TRAP_EN
               nxt = S_TRAP;
`else
               c_done = 1'b1;
`endif
            end
         end
         S_EX: begin
            dec_en = 1'b1;
            if (is_branch) begin
               c_done = 1'b1;
            end else if (is_load || is_store) begin
               nxt = S_MEM;
            end else if (WB_COMBINE != 0) begin
               c_reg_write = 1'b1;
               c_done      = 1'b1;
            end else begin
               nxt = S_WB;
            end
         end
         S_MEM: begin
            dec_en      = 1'b1;
            c_dmem_req  = 1'b1;
            c_mem_write = is_store;
            if (dmem_rdy) begin
               if (is_store) c_done = 1'b1;
               else          nxt    = S_WB;
            end
         end
         S_WB: begin
            dec_en      = 1'b1;
            c_reg_write = 1'b1;
            c_done      = 1'b1;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP: c_illegal = 1'b1;
`endif
         default: nxt = S_IF;
      endcase
      if (c_done) nxt = S_IF;
   end

   always_ff @(posedge clk) begin
      if (reset) cur <= S_IF;
      else       cur <= nxt;
   end

   // Reset is synchronous for the state register but gates every output combinationally.
   always_comb begin
      RegDst   = '0;
      RegSrc   = '0;
      ALUCtr   = '0;
      nPC_sel  = '0;
      ExtOp    = 1'b0;
      ALUSrc   = 1'b0;
      MemByte  = 1'b0;
      MemHByte = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      retire   = 1'b0;
      state    = '0;
      illegal  = 1'b0;
      if (!reset) begin
         if (dec_en) begin
            RegDst   = d_regdst;
            RegSrc   = d_regsrc;
            ALUCtr   = d_aluctr;
            nPC_sel  = d_npc;
            ExtOp    = d_extop;
            ALUSrc   = d_alusrc;
            MemByte  = d_membyte;
            MemHByte = d_memhbyte;
         end
         RegWrite = c_reg_write;
         MemWrite = c_mem_write;
         imem_req = c_imem_req;
         dmem_req = c_dmem_req;
         ir_we    = c_ir_we;
         pc_we    = c_done;
         retire   = c_done;
         state    = cur;
         illegal  = c_illegal;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized bench for mc_controller against a phase-sequence model derived from the
// class/latency rules; one DUT per WB_COMBINE value, the idle one is held in reset.
module tb_mc_controller;

   localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5;
   localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_JMP = 4, C_JAL = 5, C_ILL = 6;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      int          cls;
      logic [13:0] dec;   // {RegDst,RegSrc,ALUCtr,nPC_sel,ExtOp,ALUSrc,MemByte,MemHByte}
   } ent_t;

   ent_t tab[$];

   logic       clk;
   logic       rst0, rst1, sel;
   logic [5:0] OpCode, func;
   logic       imem_rdy, dmem_rdy;

   // {RegDst,RegSrc,ALUCtr,nPC_sel,ExtOp,ALUSrc,MemByte,MemHByte,RegWrite,MemWrite,
   //  imem_req,dmem_req,ir_we,pc_we,retire,state,illegal}
   wire [24:0] ob0, ob1, ob;
   assign ob = sel ? ob1 : ob0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   mc_controller #(.WB_COMBINE(0)) u_dut0 (
      .clk(clk), .reset(rst0), .OpCode(OpCode), .func(func),
      .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
      .RegDst(ob0[24:23]), .RegSrc(ob0[22:21]), .ALUCtr(ob0[20:17]), .nPC_sel(ob0[16:15]),
      .ExtOp(ob0[14]), .ALUSrc(ob0[13]), .MemByte(ob0[12]), .MemHByte(ob0[11]),
      .RegWrite(ob0[10]), .MemWrite(ob0[9]), .imem_req(ob0[8]), .dmem_req(ob0[7]),
      .ir_we(ob0[6]), .pc_we(ob0[5]), .retire(ob0[4]), .state(ob0[3:1]), .illegal(ob0[0])
   );

   mc_controller #(.WB_COMBINE(1)) u_dut1 (
      .clk(clk), .reset(rst1), .OpCode(OpCode), .func(func),
      .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
      .RegDst(ob1[24:23]), .RegSrc(ob1[22:21]), .ALUCtr(ob1[20:17]), .nPC_sel(ob1[16:15]),
      .ExtOp(ob1[14]), .ALUSrc(ob1[13]), .MemByte(ob1[12]), .MemHByte(ob1[11]),
      .RegWrite(ob1[10]), .MemWrite(ob1[9]), .imem_req(ob1[8]), .dmem_req(ob1[7]),
      .ir_we(ob1[6]), .pc_we(ob1[5]), .retire(ob1[4]), .state(ob1[3:1]), .illegal(ob1[0])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (dut%0d, t=%0t)", tag, got, exp, sel, $time);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic [5:0] fn, input int cls,
                      input logic [1:0] rd, input logic [1:0] rs, input logic [3:0] alu,
                      input logic [1:0] npc, input logic ext, input logic src,
                      input logic mb, input logic mhb);
      ent_t e;
      e.op  = op;
      e.fn  = fn;
      e.cls = cls;
      e.dec = {rd, rs, alu, npc, ext, src, mb, mhb};
      tab.push_back(e);
   endtask

   task automatic set_rst(input logic v);
      if (sel) rst1 = v;
      else     rst0 = v;
   endtask

   function automatic int unsigned base_lat(input int cls, input logic comb);
      case (cls)
         C_ALU:   return comb ? 3 : 4;
         C_LOAD:  return 5;
         C_STORE: return 4;
         C_BR:    return 3;
         C_JAL:   return 3;
         default: return 2;
      endcase
   endfunction

   // Drops reset of the selected DUT and checks the first cycle out of reset.
   task automatic release_check(input string tag);
      @(negedge clk);
      set_rst(1'b0);
      imem_rdy = 1'b0;
      dmem_rdy = 1'b1;
      #1;
      check_eq({tag, "_state"},    32'(ob[3:1]), 32'(P_IF));
      check_eq({tag, "_imem_req"}, 32'(ob[8]), 32'd1);
      check_eq({tag, "_dmem_req"}, 32'(ob[7]), 32'd0);
   endtask

   task automatic run_instr(input int idx, input int unsigned k, input int unsigned m);
      int          ph[$];
      int          cls;
      logic        comb;
      int unsigned ifc, memc, got_lat, exp_lat;
      cls  = tab[idx].cls;
      comb = sel;
      for (int unsigned i = 0; i <= k; i++) ph.push_back(P_IF);
      ph.push_back(P_ID);
      case (cls)
         C_JAL: ph.push_back(P_WB);
         C_BR:  ph.push_back(P_EX);
         C_ALU: begin
            ph.push_back(P_EX);
            if (!comb) ph.push_back(P_WB);
         end
         C_LOAD, C_STORE: begin
            ph.push_back(P_EX);
            for (int unsigned i = 0; i <= m; i++) ph.push_back(P_MEM);
            if (cls == C_LOAD) ph.push_back(P_WB);
         end
         default: ;
      endcase
      exp_lat = base_lat(cls, comb) + k + ((cls == C_LOAD || cls == C_STORE) ? m : 0);
      ifc = 0; memc = 0; got_lat = 0;
      for (int c = 0; c < ph.size(); c++) begin
         int   p;
         logic last, exp_rw;
         p    = ph[c];
         last = (c == ph.size() - 1);
         @(negedge clk);
         if (c == 0) begin
            OpCode = tab[idx].op;
            func   = (tab[idx].op == 6'h00) ? tab[idx].fn : 6'($urandom);
         end
         imem_rdy = (p == P_IF)  ? (ifc == k)  : 1'($urandom);
         dmem_rdy = (p == P_MEM) ? (memc == m) : 1'($urandom);
         #1;
         exp_rw = (p == P_WB) || (p == P_EX && cls == C_ALU && comb);
         check_eq("state",    32'(ob[3:1]), 32'(p));
         check_eq("imem_req", 32'(ob[8]),  32'(p == P_IF));
         check_eq("ir_we",    32'(ob[6]),  32'(p == P_IF && ifc == k));
         check_eq("dmem_req", 32'(ob[7]),  32'(p == P_MEM));
         check_eq("MemWrite", 32'(ob[9]),  32'(p == P_MEM && cls == C_STORE));
         check_eq("RegWrite", 32'(ob[10]), 32'(exp_rw));
         check_eq("retire",   32'(ob[4]),  32'(last));
         check_eq("pc_we",    32'(ob[5]),  32'(last));
         check_eq("illegal",  32'(ob[0]),  32'd0);
         check_eq("decode",   32'(ob[24:11]), (p == P_IF) ? 32'd0 : 32'(tab[idx].dec));
         if (ob[4] && got_lat == 0) got_lat = c + 1;
         if (p == P_IF)  ifc++;
         if (p == P_MEM) memc++;
      end
      check_eq("latency", got_lat, exp_lat);
   endtask

   task automatic reset_mid_load();
      int unsigned n;
      n = 0;
      @(negedge clk);
      OpCode   = 6'h23;
      func     = 6'($urandom);
      imem_rdy = 1'b1;
      dmem_rdy = 1'b0;
      #1;
      while (ob[3:1] != 3'(P_MEM) && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq("reach_mem", 32'(ob[3:1]), 32'(P_MEM));
      repeat (2) begin
         @(negedge clk);
         set_rst(1'b1);
         #1;
         check_eq("reset_mid_outputs", 32'(ob), 32'd0);
      end
      release_check("after_mid_reset");
   endtask

   task automatic run_random(input int unsigned n, input int unsigned n_pick);
      for (int unsigned i = 0; i < n; i++)
         run_instr(int'($urandom_range(0, n_pick - 1)), $urandom_range(0, 3), $urandom_range(0, 3));
   endtask

   initial begin
      int unsigned n_pick;
      rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
      OpCode = '0; func = '0; imem_rdy = 1'b0; dmem_rdy = 1'b0;

      add(6'h00, 6'h21, C_ALU,   2'b01, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); // 0 addu
      add(6'h00, 6'h23, C_ALU,   2'b01, 2'b00, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); // 1 subu
      add(6'h00, 6'h07, C_ALU,   2'b01, 2'b00, 4'd4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); // 2 srav
      add(6'h0D, 6'h00, C_ALU,   2'b00, 2'b00, 4'd2, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); // 3 ori
      add(6'h0E, 6'h00, C_ALU,   2'b00, 2'b00, 4'd6, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); // 4 xori
      add(6'h0F, 6'h00, C_ALU,   2'b00, 2'b00, 4'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); // 5 lui
      add(6'h23, 6'h00, C_LOAD,  2'b00, 2'b01, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0); // 6 lw
      add(6'h20, 6'h00, C_LOAD,  2'b00, 2'b01, 4'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0); // 7 lb
      add(6'h21, 6'h00, C_LOAD,  2'b00, 2'b01, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1); // 8 lh
      add(6'h2B, 6'h00, C_STORE, 2'b00, 2'b00, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0); // 9 sw
      add(6'h28, 6'h00, C_STORE, 2'b00, 2'b00, 4'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0); // 10 sb
      add(6'h29, 6'h00, C_STORE, 2'b00, 2'b00, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1); // 11 sh
      add(6'h04, 6'h00, C_BR,    2'b00, 2'b00, 4'd1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0); // 12 beq
      add(6'h01, 6'h00, C_BR,    2'b00, 2'b00, 4'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0); // 13 bgez
      add(6'h02, 6'h00, C_JMP,   2'b00, 2'b00, 4'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0); // 14 j
      add(6'h00, 6'h08, C_JMP,   2'b00, 2'b00, 4'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); // 15 jr
      add(6'h03, 6'h00, C_JAL,   2'b10, 2'b10, 4'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0); // 16 jal
      add(6'h00, 6'h00, C_JMP,   2'b00, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); // 17 nop
      add(6'h3F, 6'h00, C_ILL,   2'b00, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); // 18 bad opcode
      add(6'h00, 6'h3F, C_ILL,   2'b00, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); // 19 bad func
`ifdef MC_ILLEGAL_TRAP_EN
      n_pick = 18;
`else
      n_pick = 20;
`endif

      repeat (2) begin
         @(negedge clk);
         imem_rdy = 1'($urandom);
         dmem_rdy = 1'($urandom);
         #1;
         check_eq("reset_outputs", 32'(ob), 32'd0);
      end
      release_check("post_reset");

      run_instr(0, 0, 0);    // addu, 4 cycles
      run_instr(6, 0, 3);    // lw with 3 data waits, 8 cycles
      run_instr(10, 2, 0);   // sb with 2 fetch waits
      run_instr(16, 0, 0);   // jal
      run_instr(15, 0, 0);   // jr
`ifndef MC_ILLEGAL_TRAP_EN
      run_instr(18, 0, 0);   // illegal retires as NOP
`endif
      run_random(150, n_pick);
      reset_mid_load();
      run_random(20, n_pick);

      @(negedge clk);
      rst0 = 1'b1;
      sel  = 1'b1;
      #1;
      check_eq("dut1_reset_outputs", 32'(ob), 32'd0);
      release_check("dut1_post_reset");
      run_instr(0, 0, 0);    // addu with write-back folded into EX, 3 cycles
      run_instr(3, 1, 0);
      run_random(100, n_pick);

`ifdef MC_ILLEGAL_TRAP_EN
      @(negedge clk);
      OpCode   = 6'h3F;
      func     = 6'($urandom);
      imem_rdy = 1'b1;
      #1;
      check_eq("trap_if_state", 32'(ob[3:1]), 32'(P_IF));
      @(negedge clk);
      imem_rdy = 1'($urandom);
      #1;
      check_eq("trap_id_state", 32'(ob[3:1]), 32'(P_ID));
      check_eq("trap_id_retire", 32'(ob[4]), 32'd0);
      repeat (10) begin
         @(negedge clk);
         imem_rdy = 1'($urandom);
         dmem_rdy = 1'($urandom);
         #1;
         check_eq("trap_state",   32'(ob[3:1]), 32'(P_TRAP));
         check_eq("trap_illegal", 32'(ob[0]), 32'd1);
         check_eq("trap_strobes", 32'(ob[10:4]), 32'd0);
         check_eq("trap_decode",  32'(ob[24:11]), 32'd0);
      end
      @(negedge clk);
      set_rst(1'b1);
      #1;
      check_eq("trap_reset_outputs", 32'(ob), 32'd0);
      release_check("after_trap");
      run_instr(12, 0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
